// File: rtl/posi_satd_cost_ctrl_pkg.sv
// Shared definitions for the post-intra SATD cost controller.
// - SIZE_* : CU size codes carried on size_i / tp_size_o
// - state_e: controller FSM states
// - last_beat_of / blocks_of: per-size beat and partial-sum counts
package posi_satd_cost_ctrl_pkg;

    localparam logic [1:0] SIZE_04 = 2'd0;
    localparam logic [1:0] SIZE_08 = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Index of the final row-pair beat for a CU (beats - 1).
    function automatic logic [5:0] last_beat_of(input logic [1:0] sz);
        case (sz)
            SIZE_04: return 6'd0;
            SIZE_08: return 6'd3;
            SIZE_16: return 6'd15;
            default: return 6'd63;
        endcase
    endfunction

    // Number of 8x8 (or single 4x4) partial sums the datapath returns.
    function automatic logic [4:0] blocks_of(input logic [1:0] sz);
        case (sz)
            SIZE_04: return 5'd1;
            SIZE_08: return 5'd1;
            SIZE_16: return 5'd4;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/posi_satd_cost_ctrl_if.sv
// Datapath-side bus of the SATD cost controller.
// - rd_val_o/rd_blk_o/rd_row_o : residual beat request (controller -> read port)
// - tp_val_o/tp_size_o         : transpose buffer strobe and CU size
// - sum_val_i/sum_dat_i        : per-block partial sum from the vertical stage
interface posi_satd_cost_ctrl_if #(
    parameter int SUM_WIDTH = 16
);
    logic                 rd_val_o;
    logic [3:0]           rd_blk_o;
    logic [1:0]           rd_row_o;
    logic                 tp_val_o;
    logic [1:0]           tp_size_o;
    logic                 sum_val_i;
    logic [SUM_WIDTH-1:0] sum_dat_i;

    modport master (
        output rd_val_o, rd_blk_o, rd_row_o, tp_val_o, tp_size_o,
        input  sum_val_i, sum_dat_i
    );

    modport slave (
        input  rd_val_o, rd_blk_o, rd_row_o, tp_val_o, tp_size_o,
        output sum_val_i, sum_dat_i
    );
endinterface

// File: rtl/posi_satd_cost_acc.sv
// Saturating partial-sum accumulator with size-dependent rounding.
// - i_clr  : clear accumulator (DONE cycle)
// - i_add  : add i_dat this cycle (saturating at 2^COST_WIDTH-1)
// - i_load : capture rounded cost of the post-add value into o_cost
// - i_size : CU size, selects >>1 (4x4) or >>2 rounding
// - o_cost : held rounded cost
module posi_satd_cost_acc
    import posi_satd_cost_ctrl_pkg::*;
#(
    parameter int SUM_WIDTH  = 16,
    parameter int COST_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_add,
    input  logic [SUM_WIDTH-1:0]  i_dat,
    input  logic                  i_load,
    input  logic [1:0]            i_size,
    output logic [COST_WIDTH-1:0] o_cost
);
    logic [COST_WIDTH-1:0] r_acc;
    logic [COST_WIDTH:0]   w_sum;
    logic [COST_WIDTH-1:0] w_acc_nxt;
    logic [COST_WIDTH:0]   w_rnd;
    logic [COST_WIDTH-1:0] w_rnd_sat;
    logic [COST_WIDTH-1:0] w_cost;

    always_comb begin
        w_sum     = {1'b0, r_acc} + (COST_WIDTH+1)'(i_dat);
        w_acc_nxt = r_acc;
        if (i_add)
            w_acc_nxt = w_sum[COST_WIDTH] ? '1 : w_sum[COST_WIDTH-1:0];
        // Rounding is applied to the value including this cycle's strobe,
        // and clamped before the shift so a saturated acc never wraps.
        w_rnd     = {1'b0, w_acc_nxt} +
                    ((i_size == SIZE_04) ? (COST_WIDTH+1)'(1) : (COST_WIDTH+1)'(2));
        w_rnd_sat = w_rnd[COST_WIDTH] ? '1 : w_rnd[COST_WIDTH-1:0];
        w_cost    = (i_size == SIZE_04) ? (w_rnd_sat >> 1) : (w_rnd_sat >> 2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            o_cost <= '0;
        end else begin
            r_acc <= i_clr ? '0 : w_acc_nxt;
            if (i_load)
                o_cost <= w_cost;
        end
    end
endmodule

// File: rtl/posi_satd_cost_ctrl.sv
// Post-intra SATD cost sequencer: one cost evaluation per CU.
// - start_i/size_i : request (sampled in IDLE only)
// - busy_o         : accepted start through DONE cycle
// - dp (master)    : beat requests, transpose strobe, partial sums back
// - done_o/cost_o  : one-cycle completion pulse, held rounded cost
module posi_satd_cost_ctrl
    import posi_satd_cost_ctrl_pkg::*;
#(
    parameter int SUM_WIDTH  = 16,
    parameter int COST_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            size_i,
    output logic                  busy_o,
    posi_satd_cost_ctrl_if.master dp,
    output logic                  done_o,
    output logic [COST_WIDTH-1:0] cost_o
);
    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_size;
    logic [5:0] r_beat;
    logic [4:0] r_ret;
    logic       r_tp_val;
    logic       w_accept;
    logic       w_rd_val;
    logic       w_last_beat;
    logic       w_sum_take;
    logic [4:0] w_ret_nxt;

    // Sums count only while ISSUE/DRAIN and only until the expected count.
    always_comb begin
        w_rd_val    = (r_state == ST_ISSUE);
        w_last_beat = (r_beat == last_beat_of(r_size));
        w_sum_take  = dp.sum_val_i &&
                      ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) &&
                      (r_ret != blocks_of(r_size));
        w_ret_nxt   = r_ret + 5'(w_sum_take);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_ISSUE;
                    w_accept    = 1'b1;
                end
            end
            ST_ISSUE: if (w_last_beat) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_ret_nxt == blocks_of(r_size)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_size   <= '0;
            r_beat   <= '0;
            r_ret    <= '0;
            r_tp_val <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tp_val <= w_rd_val;
            if (w_accept)
                r_size <= size_i;
            if (r_state == ST_DONE) begin
                r_beat <= '0;
                r_ret  <= '0;
            end else begin
                r_ret <= w_ret_nxt;
                if ((r_state == ST_ISSUE) && !w_last_beat)
                    r_beat <= r_beat + 6'd1;
            end
        end
    end

    // Beat counter doubles as read address: upper bits block, lower bits row pair.
    assign dp.rd_val_o  = w_rd_val;
    assign dp.rd_blk_o  = r_beat[5:2];
    assign dp.rd_row_o  = r_beat[1:0];
    assign dp.tp_val_o  = r_tp_val;
    assign dp.tp_size_o = r_size;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);

    posi_satd_cost_acc #(
        .SUM_WIDTH (SUM_WIDTH),
        .COST_WIDTH(COST_WIDTH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == ST_DONE),
        .i_add (w_sum_take),
        .i_dat (dp.sum_dat_i),
        .i_load(w_state_nxt == ST_DONE),
        .i_size(r_size),
        .o_cost(cost_o)
    );
endmodule

// File: tb/tb_posi_satd_cost_ctrl.sv
module tb_posi_satd_cost_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  size = '0;
    logic        sum_val = 1'b0;
    logic [15:0] sum_dat = '0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [19:0] cost_a;
    logic [16:0] cost_b;

    always #5 clk = ~clk;

    posi_satd_cost_ctrl_if #(.SUM_WIDTH(16)) ifa ();
    posi_satd_cost_ctrl_if #(.SUM_WIDTH(16)) ifb ();
    assign ifa.sum_val_i = sum_val;
    assign ifa.sum_dat_i = sum_dat;
    assign ifb.sum_val_i = sum_val;
    assign ifb.sum_dat_i = sum_dat;

    posi_satd_cost_ctrl #(.SUM_WIDTH(16), .COST_WIDTH(20)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .size_i(size), .busy_o(busy_a),
        .dp(ifa), .done_o(done_a), .cost_o(cost_a));

    posi_satd_cost_ctrl #(.SUM_WIDTH(16), .COST_WIDTH(17)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .size_i(size), .busy_o(busy_b),
        .dp(ifb), .done_o(done_b), .cost_o(cost_b));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int beats_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One CU = nbeats beat requests starting the cycle after acceptance,
    // then completion once every beat is out and nsums sums have arrived.
    int     W [2] = '{20, 17};
    bit     m_busy = 0, m_done = 0, m_tpv = 0;
    int     m_size = 0, m_beat = 0, m_nbeats = 0, m_nsums = 0, m_got = 0;
    longint m_acc [2] = '{0, 0};
    longint m_cost[2] = '{0, 0};

    function automatic longint maxv(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint rnd_cost(input longint acc, input int sz, input int w);
        longint t;
        t = acc + ((sz == 0) ? 1 : 2);
        if (t > maxv(w)) t = maxv(w);
        return (sz == 0) ? (t >> 1) : (t >> 2);
    endfunction

    always @(posedge clk) begin
        bit iss;
        iss = m_busy && !m_done && (m_beat < m_nbeats);
        if (rst) begin
            m_busy = 0; m_done = 0; m_tpv = 0; m_size = 0; m_beat = 0;
            m_nbeats = 0; m_nsums = 0; m_got = 0;
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_cost[k] = 0; end
        end else begin
            m_tpv = iss;
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_size = int'(size);
                    m_nbeats = 1 << (2 * m_size);
                    m_nsums  = (m_size == 0) ? 1 : (1 << (2 * (m_size - 1)));
                    m_beat = 0; m_got = 0;
                    for (int k = 0; k < 2; k++) m_acc[k] = 0;
                end
            end else begin
                if (sum_val && (m_got < m_nsums)) begin
                    m_got++;
                    for (int k = 0; k < 2; k++) begin
                        m_acc[k] = m_acc[k] + longint'(sum_dat);
                        if (m_acc[k] > maxv(W[k])) m_acc[k] = maxv(W[k]);
                    end
                end
                if (iss) m_beat++;
                else if (m_got == m_nsums) begin
                    m_done = 1;
                    for (int k = 0; k < 2; k++) m_cost[k] = rnd_cost(m_acc[k], m_size, W[k]);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit exp_rdv;
        exp_rdv = m_busy && !m_done && (m_beat < m_nbeats);
        if (chk_en) begin
            chk("busy_a", busy_a, m_busy);
            chk("busy_b", busy_b, m_busy);
            chk("done_a", done_a, m_done);
            chk("done_b", done_b, m_done);
            chk("cost_a", cost_a, m_cost[0]);
            chk("cost_b", cost_b, m_cost[1]);
            chk("rd_val_a", ifa.rd_val_o, exp_rdv);
            chk("rd_val_b", ifb.rd_val_o, exp_rdv);
            chk("tp_val_a", ifa.tp_val_o, m_tpv);
            chk("tp_val_b", ifb.tp_val_o, m_tpv);
            if (exp_rdv) begin
                chk("rd_blk_a", ifa.rd_blk_o, m_beat / 4);
                chk("rd_row_a", ifa.rd_row_o, m_beat % 4);
                chk("rd_blk_b", ifb.rd_blk_o, m_beat / 4);
                chk("rd_row_b", ifb.rd_row_o, m_beat % 4);
            end
            if (m_tpv) begin
                chk("tp_size_a", ifa.tp_size_o, m_size);
                chk("tp_size_b", ifb.tp_size_o, m_size);
            end
            if (ifa.rd_val_o) beats_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // val < 0 : random sums; exp_a/exp_b < 0 : no literal expectation.
    task automatic run_cu(input int sz, input int nsum, input int val, input int first_gap,
                          input int max_gap, input bit noise, input bit bstart,
                          input longint exp_a, input longint exp_b);
        int  b0;
        bit  ok;
        @(posedge clk); #1;
        b0 = beats_seen;
        start = 1'b1; size = 2'(sz);
        tick();
        start = 1'b0;
        if (bstart) begin
            start = 1'b1; size = 2'd3;
            tick();
            start = 1'b0;
        end
        repeat (first_gap) tick();
        for (int i = 0; i < nsum; i++) begin
            sum_val = 1'b1;
            sum_dat = (val < 0) ? 16'($urandom) : 16'(val);
            if (noise && ($urandom_range(0, 3) == 0)) begin
                start = 1'b1; size = 2'($urandom_range(0, 3));
            end
            tick();
            sum_val = 1'b0; start = 1'b0;
            if ((i != nsum - 1) && (max_gap > 0)) repeat ($urandom_range(0, max_gap)) tick();
        end
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done_a) begin ok = 1'b1; break; end
        end
        chk("done_seen", ok, 1);
        chk("beat_count", beats_seen - b0, 1 << (2 * sz));
        if (exp_a >= 0) begin
            chk("lit_cost_a", cost_a, exp_a);
            chk("lit_model_a", m_cost[0], exp_a);
        end
        if (exp_b >= 0) begin
            chk("lit_cost_b", cost_b, exp_b);
            chk("lit_model_b", m_cost[1], exp_b);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_rd_val", ifa.rd_val_o, 0);
        chk("rst_tp_val", ifa.tp_val_o, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cost", cost_a, 0);
        chk("rst_blk_row", {ifa.rd_blk_o, ifa.rd_row_o}, 0);
        chk("rst_tp_size", ifa.tp_size_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 8x8: one sum of 1000 -> (1000+2)>>2
        run_cu(1, 1, 1000, 5, 0, 0, 0, 250, 250);
        @(negedge clk);
        chk("busy_after_done", busy_a, 0);

        // 4x4 with a 32x32 start during busy -> single beat, (7+1)>>1
        run_cu(0, 1, 7, 2, 0, 0, 1, 4, 4);

        // 32x32: sums from cycle 59, several overlapping ISSUE
        run_cu(3, 16, 100, 58, 0, 0, 0, 400, 400);

        // 16x16 saturation: 20-bit holds 262140, 17-bit clamps to 131071
        run_cu(2, 4, 65535, 20, 1, 0, 0, 65535, 32767);

        // stray sum in IDLE ignored
        @(posedge clk); #1;
        sum_val = 1'b1; sum_dat = 16'd55;
        tick();
        sum_val = 1'b0;
        run_cu(1, 1, 8, 3, 0, 0, 0, 2, 2);

        // reset during 16x16 beat 9
        @(posedge clk); #1;
        start = 1'b1; size = 2'd2;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_rd_val", ifa.rd_val_o, 0);
        chk("midrst_cost", cost_a, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            sum_val = 1'b1; sum_dat = 16'd500;
            tick();
        end
        sum_val = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("postrst_cost", cost_a, 0);
        chk("postrst_busy", busy_a, 0);

        // back-to-back: second start in the cycle after done_o
        run_cu(1, 1, 40, 1, 0, 0, 0, 10, 10);
        run_cu(0, 1, 3, 0, 0, 0, 0, 2, 2);

        // randomized CUs
        for (int r = 0; r < 40; r++) begin
            int sz;
            sz = $urandom_range(0, 3);
            run_cu(sz, (sz == 0) ? 1 : (1 << (2 * (sz - 1))), -1,
                   $urandom_range(0, 70), $urandom_range(0, 3), 1'b1, 1'b0, -1, -1);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
